airflow_classifier: RTL

AIRFLOW_CLASSIFIER -- requirements
Module: airflow_classifier

---
 rtl/airflow_classifier.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/airflow_classifier.sv
// Windowed audio-magnitude airflow classifier: per-level sample histograms decide a registered level.
// Optional hysteresis on level changes is enabled by defining AIRFLOW_HYST_EN.
module airflow_classifier #(
  parameter int                  SAMPLE_W     = 32,
  parameter int                  LEVELS       = 3,
  parameter int                  WINDOW       = 16,
  parameter logic [SAMPLE_W-1:0] TH1          = SAMPLE_W'(32'h001F_FF00),
  parameter logic [SAMPLE_W-1:0] TH2          = SAMPLE_W'(32'h01FF_E000),
  parameter logic [SAMPLE_W-1:0] TH3          = SAMPLE_W'(32'h7FFF_FFFF),
  parameter int                  HYST_WINDOWS = 2,
  localparam int                 CNT_W        = $clog2(WINDOW + 1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                mute,
  output logic [1:0]          air,
  output logic                win_done,
  output logic [CNT_W-1:0]    bin0,
  output logic [CNT_W-1:0]    bin1,
  output logic [CNT_W-1:0]    bin2,
  output logic [CNT_W-1:0]    bin3
);

  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [1:0]          air_q, air_d;
  logic                win_done_q, win_done_d;
  logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]    cnt_q [4];
  logic [CNT_W-1:0]    cnt_d [4];
  logic [CNT_W-1:0]    bin_q [4];
  logic [CNT_W-1:0]    bin_d [4];
  logic [CNT_W-1:0]    new_cnt [4];
  logic [SAMPLE_W-1:0] mag;
  logic [1:0]          lvl;
  logic [1:0]          winner;
  logic                has_win;
  logic                is_max;
  logic                closing;
  logic [1:0]          cand;

`ifdef AIRFLOW_HYST_EN
  localparam logic [3:0] HYST_N = 4'(HYST_WINDOWS);
  logic [1:0] streak_lvl_q, streak_lvl_d;
  logic [3:0] streak_cnt_q, streak_cnt_d;
  logic [3:0] streak_next;
`else
  logic unused_hyst;
  assign unused_hyst = ^HYST_WINDOWS;
`endif

  // The most negative sample has no positive twin, so it saturates.
  always_comb begin
    if (sample_in == MOST_NEG) begin
      mag = MOST_POS;
    end else if (sample_in[SAMPLE_W-1]) begin
      mag = SAMPLE_W'(0) - sample_in;
    end else begin
      mag = sample_in;
    end
    lvl = 2'd0;
    if (mag > TH1) lvl = lvl + 2'd1;
    if (LEVELS > 2 && mag > TH2) lvl = lvl + 2'd1;
    if (LEVELS > 3 && mag > TH3) lvl = lvl + 2'd1;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      new_cnt[i] = cnt_q[i];
    end
    new_cnt[lvl] = cnt_q[lvl] + CNT_W'(1);
  end

  // A winner must strictly beat every other active level.
  always_comb begin
    has_win = 1'b0;
    winner  = 2'd0;
    is_max  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < LEVELS) begin
        is_max = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (j < LEVELS && j != i && new_cnt[i] <= new_cnt[j]) is_max = 1'b0;
        end
        if (is_max) begin
          has_win = 1'b1;
          winner  = 2'(i);
        end
      end
    end
  end

  assign closing = sample_valid && (win_cnt_q == CNT_W'(WINDOW - 1));
  assign cand    = mute ? 2'd0 : (has_win ? winner : air_q);

  always_comb begin
    air_d      = air_q;
    win_done_d = 1'b0;
    win_cnt_d  = win_cnt_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      bin_d[i] = bin_q[i];
    end
`ifdef AIRFLOW_HYST_EN
    streak_lvl_d = streak_lvl_q;
    streak_cnt_d = streak_cnt_q;
    streak_next  = 4'd1;
`endif
    if (sample_valid) begin
      if (closing) begin
        win_done_d = 1'b1;
        win_cnt_d  = '0;
        for (int i = 0; i < 4; i++) begin
          cnt_d[i] = '0;
          bin_d[i] = new_cnt[i];
        end
`ifdef AIRFLOW_HYST_EN
        // A streak only continues while the same differing candidate keeps winning.
        if (mute) begin
          air_d        = 2'd0;
          streak_cnt_d = 4'd0;
        end else if (cand == air_q) begin
          streak_cnt_d = 4'd0;
        end else begin
          if (cand == streak_lvl_q && streak_cnt_q != 4'd0) streak_next = streak_cnt_q + 4'd1;
          if (streak_next >= HYST_N) begin
            air_d        = cand;
            streak_cnt_d = 4'd0;
          end else begin
            streak_lvl_d = cand;
            streak_cnt_d = streak_next;
          end
        end
`else
        air_d = cand;
`endif
      end else begin
        win_cnt_d = win_cnt_q + CNT_W'(1);
        for (int i = 0; i < 4; i++) begin
          cnt_d[i] = new_cnt[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      air_q      <= 2'd0;
      win_done_q <= 1'b0;
      win_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        bin_q[i] <= '0;
      end
`ifdef AIRFLOW_HYST_EN
      streak_lvl_q <= 2'd0;
      streak_cnt_q <= 4'd0;
`endif
    end else begin
      air_q      <= air_d;
      win_done_q <= win_done_d;
      win_cnt_q  <= win_cnt_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        bin_q[i] <= bin_d[i];
      end
`ifdef AIRFLOW_HYST_EN
      streak_lvl_q <= streak_lvl_d;
      streak_cnt_q <= streak_cnt_d;
`endif
    end
  end

  assign air      = air_q;
  assign win_done = win_done_q;
  assign bin0     = bin_q[0];
  assign bin1     = bin_q[1];
  assign bin2     = bin_q[2];
  assign bin3     = bin_q[3];

endmodule
